wrr_fifo_scheduler: RTL and testbench
=====================================

# wrr_fifo_scheduler

Weighted round-robin read scheduler for a bank of four 8-bit FIFOs feeding one shared output. Each cycle it looks at the FIFO empty flags and issues at most one one-hot read enable, giving each queue up to `weight` consecutive grants before moving on. Empty and disabled queues are skipped, so no cycle is wasted when another queue has data. It also registers the granted index one cycle later so the downstream output mux lines up with FIFO read data.

## Interface
- `NUM_Q`, 4: number of queues; fixed at 4 for this block.
- `WW`, 3: weight width; legal weights are 0..7.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `empty`  in  NUM_Q  per-FIFO empty flag; bit 0 = queue a, bit 3 = queue d.
- `stall`  in  1  downstream back-pressure; while high, no grant is issued and state is frozen.
- `weight_wr`  in  1  weight register write strobe.
- `weight_sel`  in  2  index of the weight register being written.
- `weight_din`  in  WW  weight value to write.
- `ren`  out  NUM_Q  one-hot FIFO read enable, or all zero; combinational (Mealy) in the current cycle.
- `gnt_idx_q`  out  2  index of the queue granted in the previous cycle.
- `gnt_valid_q`  out  1  high if a grant was issued in the previous cycle; qualifies FIFO dout.

## Operation
- **State:**
  - `ptr` (2b): current queue.
  - `credit` (WW bits): grants remaining for `ptr`.
  - `weight[0..3]`.
- **Eligible queue:** `!empty[q] && weight[q] != 0`.
- **Each cycle with `stall=0` and `rst_n=1`:**
  - **Continue:** if `ptr` is eligible and `credit > 0`, grant `ptr` and set `credit <= credit-1`.
  - **Reload:** otherwise, search `ptr+1, ptr+2, ptr+3, ptr` (mod 4) for the first eligible queue `c`. Grant `c`, then set `ptr <= c` and `credit <= weight[c]-1`.
  - **Idle:** if no queue is eligible, `ren=0` and `ptr`/`credit` are unchanged.
- **Credit rules:**
  - If `ptr` becomes empty mid-burst, its remaining credit is forfeited. The next grant goes through the reload path.
  - If `ptr` is the only eligible queue, it is reloaded and granted again every cycle, with no gap.
- **Weight writes:**
  - A write takes effect at the clock edge and is used at the next reload only. It never modifies `credit` in flight.
  - On a write and a reload of the same queue in the same cycle, the reload uses the old weight.
  - Weight 0 disables the queue. It is never granted, even when non-empty.
- **Stall:** `ren=0`, `ptr`/`credit` hold, weight writes still apply, and `gnt_valid_q` goes 0 the next cycle.
- **Registered outputs:** `gnt_idx_q <= index of ren` and `gnt_valid_q <= |ren`, every cycle.

## Timing
- **Reset (`rst_n=0` at an edge):**
  - `ptr=3`, so the first search starts at queue 0.
  - `credit=0`, all weights `=1` (plain round robin).
  - `gnt_idx_q=0`, `gnt_valid_q=0`.
  - `ren` is forced to 0 combinationally while `rst_n=0`.
- **Reset mid-burst:** credit is discarded, and the first grant after release goes to the lowest-index eligible queue.
- **Latency:**
  - `ren` is asserted in the same cycle `empty` shows data.
  - FIFO dout and `gnt_valid_q`/`gnt_idx_q` are valid one cycle after `ren`.
- **Read safety:** `ren[q]` is never asserted while `empty[q]=1`.
- **Throughput:** one grant per cycle whenever any queue is eligible and `stall=0`.
- **Arithmetic:** the credit decrement never underflows, because the decrement is only taken when `credit > 0`. `weight-1` is only computed when `weight != 0`.

## Structure
- **Shared package `fifo_arb_pkg`:**
  - `NUM_Q`, `IDX_W=2`, `WW`.
  - Default weight constant `W_DEFAULT=1`.
- **Sub-module `rr_pick`:** combinational rotate-and-priority search. Inputs are the eligible mask and start index; outputs are `found` and `idx`. It is reusable by the existing arbiter.
- **Top level:** state registers, weight register file, and the grant/credit logic.

## Test plan
- **Default round robin:** after reset, all non-empty, no weight writes. Expect `ren` = 0001, 0010, 0100, 1000, 0001. `gnt_valid_q` is 1 from the cycle after the first grant, and `gnt_idx_q` lags `ren` by one cycle.
- **Weighted sequence:** write weights a=3, b=1, c=0, d=2, then keep all queues non-empty. Expect `ren` = 0001×3, 0010, 1000×2, 0001×3. Queue c is never granted.
- **Skip and sole queue:** only c non-empty with weight 1. Expect `ren` = 0100 every cycle. When c drains, `ren` = 0000 in the cycle `empty[2]` rises, and `gnt_valid_q` = 0 the following cycle.
- **Mid-burst empty:** weight a=4, all non-empty. Assert `empty[0]` after 2 grants to a. The next grant is b (0010). When a is granted again later, it receives a fresh 4-grant burst.
- **Stall:** assert `stall` during d's second of 2 grants. `ren` = 0000 while stalled. After release, `ren` = 1000 once, then 0001.
- **Reset mid-operation:** apply reset while b holds credit 2, with a non-empty. The first post-reset grant is `ren` = 0001, all weights read back as 1, and `gnt_valid_q` = 0 during reset.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fifo_arb_pkg                                               |
// | Brief   : Shared sizes, default weight and a one-hot helper for the  |
// |           FIFO read arbiters.                                        |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package fifo_arb_pkg;

   localparam int NUM_Q = 4;   // queues in the bank
   localparam int IDX_W = 2;   // bits needed to index a queue
   localparam int WW    = 3;   // weight / credit width

   // Out of reset every queue gets one grant per turn: plain round robin.
   localparam logic [WW-1:0] W_DEFAULT = 3'd1;

   // Encode a one-hot (or all-zero) vector into its bit index.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_Q-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_Q; i++) begin
         if (oh[i]) begin
            idx = idx | IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_pick                                                    |
// | Brief   : Combinational rotate-and-priority search. Returns the      |
// |           first set bit of elig_i at or after start_i, wrapping.     |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick #(
   parameter int NUM_Q = fifo_arb_pkg::NUM_Q,
   parameter int IDX_W = fifo_arb_pkg::IDX_W
) (
   input  logic [NUM_Q-1:0] elig_i,
   input  logic [IDX_W-1:0] start_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   import fifo_arb_pkg::*;

   logic [IDX_W-1:0] w_cand;

   // Walk offsets from farthest to nearest so the nearest eligible queue
   // (lowest rotation offset from start_i) overwrites any later one.
   // Index arithmetic wraps in IDX_W bits because NUM_Q is a power of two.
   always_comb begin
      found_o = 1'b0;
      idx_o   = start_i;
      w_cand  = '0;
      for (int k = NUM_Q - 1; k >= 0; k--) begin
         w_cand = start_i + IDX_W'(k);
         if (elig_i[w_cand]) begin
            found_o = 1'b1;
            idx_o   = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wrr_fifo_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wrr_fifo_scheduler                                         |
// | Brief   : Weighted round-robin read scheduler for four FIFOs. Issues |
// |           at most one one-hot read enable per cycle, giving each     |
// |           queue up to weight consecutive grants, and registers the   |
// |           granted index to align with FIFO read data.                |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module wrr_fifo_scheduler #(
   parameter int NUM_Q = fifo_arb_pkg::NUM_Q,
   parameter int WW    = fifo_arb_pkg::WW
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_Q-1:0]              empty,
   input  logic                          stall,
   input  logic                          weight_wr,
   input  logic [fifo_arb_pkg::IDX_W-1:0] weight_sel,
   input  logic [WW-1:0]                 weight_din,
   output logic [NUM_Q-1:0]              ren,
   output logic [fifo_arb_pkg::IDX_W-1:0] gnt_idx_q,
   output logic                          gnt_valid_q
);

   import fifo_arb_pkg::*;

   // Scheduler state
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [WW-1:0]    credit_q, credit_d;
   logic [WW-1:0]    weight_q [NUM_Q];

   // Combinational decision signals
   logic [NUM_Q-1:0] w_elig;
   logic [IDX_W-1:0] w_start;
   logic             w_found;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_grant;
   logic [IDX_W-1:0] w_gidx;

   // A queue competes only when it holds data and is not disabled by weight 0.
   for (genvar q = 0; q < NUM_Q; q++) begin : g_elig
      assign w_elig[q] = !empty[q] && (weight_q[q] != '0);
   end

   // The reload search begins just past the current queue and ends on it,
   // so a sole eligible queue is found again with no idle cycle.
   assign w_start = ptr_q + IDX_W'(1);

   rr_pick #(
      .NUM_Q (NUM_Q),
      .IDX_W (IDX_W)
   ) u_pick (
      .elig_i  (w_elig),
      .start_i (w_start),
      .found_o (w_found),
      .idx_o   (w_pick_idx)
   );

   // Grant decision: continue the current burst while credit remains,
   // otherwise reload from the next eligible queue; nothing moves in
   // reset or stall. A queue that empties mid-burst falls to the reload
   // path, which forfeits its leftover credit.
   always_comb begin
      w_grant  = 1'b0;
      w_gidx   = ptr_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      if (rst_n && !stall) begin
         if (w_elig[ptr_q] && (credit_q != '0)) begin
            w_grant  = 1'b1;
            credit_d = credit_q - WW'(1);
         end else if (w_found) begin
            // w_found implies weight_q[w_pick_idx] != 0, so no underflow.
            w_grant  = 1'b1;
            w_gidx   = w_pick_idx;
            ptr_d    = w_pick_idx;
            credit_d = weight_q[w_pick_idx] - WW'(1);
         end
      end
   end

   // One-hot read enable from the chosen index.
   always_comb begin
      ren = '0;
      if (w_grant) begin
         ren[w_gidx] = 1'b1;
      end
   end

   // Pointer and credit registers; reset parks the pointer on the last
   // queue so the first search starts at queue 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q    <= IDX_W'(NUM_Q - 1);
         credit_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
      end
   end

   // Weight register file; writes land at the edge, so a reload in the
   // same cycle still sees the old value. Writes are accepted during stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int q = 0; q < NUM_Q; q++) begin
            weight_q[q] <= W_DEFAULT;
         end
      end else if (weight_wr) begin
         weight_q[weight_sel] <= weight_din;
      end
   end

   // Grant pipeline stage aligned with FIFO read data; the index holds
   // its last value when no grant is issued.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
      end else begin
         gnt_valid_q <= |ren;
         if (|ren) begin
            gnt_idx_q <= onehot_to_idx(ren);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wrr_fifo_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_wrr_fifo_scheduler                                      |
// | Brief   : Directed, table-driven bench for wrr_fifo_scheduler with   |
// |           a hand-written same-cycle write/reload sequence.           |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_wrr_fifo_scheduler;

   logic       clk;
   logic       rst_n;
   logic [3:0] empty;
   logic       stall;
   logic       weight_wr;
   logic [1:0] weight_sel;
   logic [2:0] weight_din;
   logic [3:0] ren;
   logic [1:0] gnt_idx_q;
   logic       gnt_valid_q;

   int total = 0;
   int bad   = 0;

   wrr_fifo_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .empty       (empty),
      .stall       (stall),
      .weight_wr   (weight_wr),
      .weight_sel  (weight_sel),
      .weight_din  (weight_din),
      .ren         (ren),
      .gnt_idx_q   (gnt_idx_q),
      .gnt_valid_q (gnt_valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // chk: 0 = ren only, 1 = ren + valid, 2 = ren + valid + index
   typedef struct {
      logic       rst_n;
      logic [3:0] empty;
      logic       stall;
      logic       wr;
      logic [1:0] sel;
      logic [2:0] din;
      logic [3:0] ren;
      logic       v;
      logic [1:0] idx;
      int         chk;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] e, input logic s,
                      input logic w, input logic [1:0] sl, input logic [2:0] d,
                      input logic [3:0] er, input logic ev, input logic [1:0] ei,
                      input int c);
      vec_t t;
      t.rst_n = r; t.empty = e; t.stall = s; t.wr = w; t.sel = sl; t.din = d;
      t.ren = er; t.v = ev; t.idx = ei; t.chk = c;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] e, input logic s,
                        input logic w, input logic [1:0] sl, input logic [2:0] d);
      @(negedge clk);
      rst_n = r; empty = e; stall = s; weight_wr = w; weight_sel = sl; weight_din = d;
      #2;
   endtask

   initial begin
      rst_n = 1'b0; empty = 4'hF; stall = 1'b0;
      weight_wr = 1'b0; weight_sel = 2'd0; weight_din = 3'd0;

      // reset
      add(0,4'b0000,0,0,0,0, 4'b0000,0,0,0);
      add(0,4'b0000,0,0,0,0, 4'b0000,0,0,2);
      // default round robin
      add(1,4'b0000,0,0,0,0, 4'b0001,0,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0010,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0100,1,1,2);
      add(1,4'b0000,0,0,0,0, 4'b1000,1,2,2);
      // weight writes a=3 b=1 c=0 d=2 under stall
      add(1,4'b0000,1,1,0,3, 4'b0000,1,3,2);
      add(1,4'b0000,1,1,1,1, 4'b0000,0,0,1);
      add(1,4'b0000,1,1,2,0, 4'b0000,0,0,1);
      add(1,4'b0000,1,1,3,2, 4'b0000,0,0,1);
      // weighted sequence
      add(1,4'b0000,0,0,0,0, 4'b0001,0,0,1);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0010,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b1000,1,1,2);
      add(1,4'b0000,0,0,0,0, 4'b1000,1,3,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,3,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,0,2);
      // stall during d's second grant
      add(1,4'b0000,0,0,0,0, 4'b0010,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b1000,1,1,2);
      add(1,4'b0000,1,0,0,0, 4'b0000,1,3,2);
      add(1,4'b0000,0,0,0,0, 4'b1000,0,0,1);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,3,2);
      // mid-burst empty with a=4
      add(1,4'b0000,1,1,0,4, 4'b0000,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,0,0,1);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0010,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b1000,1,1,2);
      add(1,4'b0000,0,0,0,0, 4'b1000,1,3,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,3,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,0,2);
      add(1,4'b0001,0,0,0,0, 4'b0010,1,0,2);
      add(1,4'b0001,0,0,0,0, 4'b1000,1,1,2);
      add(1,4'b0000,0,0,0,0, 4'b1000,1,3,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,3,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0010,1,0,2);
      // sole queue c, then c drains
      add(1,4'b1011,1,1,2,1, 4'b0000,1,1,2);
      add(1,4'b1011,0,0,0,0, 4'b0100,0,0,1);
      add(1,4'b1011,0,0,0,0, 4'b0100,1,2,2);
      add(1,4'b1011,0,0,0,0, 4'b0100,1,2,2);
      add(1,4'b1111,0,0,0,0, 4'b0000,1,2,2);
      add(1,4'b1111,0,0,0,0, 4'b0000,0,0,1);
      // reset while b holds credit 2
      add(1,4'b0000,1,1,1,3, 4'b0000,0,0,1);
      add(1,4'b1101,0,0,0,0, 4'b0010,0,0,1);
      add(0,4'b1100,0,0,0,0, 4'b0000,1,1,2);
      add(0,4'b1100,0,0,0,0, 4'b0000,0,0,2);
      add(1,4'b1100,0,0,0,0, 4'b0001,0,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0010,1,0,2);
      add(1,4'b0000,0,0,0,0, 4'b0100,1,1,2);
      add(1,4'b0000,0,0,0,0, 4'b1000,1,2,2);
      add(1,4'b0000,0,0,0,0, 4'b0001,1,3,2);

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].empty, vecs[i].stall,
               vecs[i].wr, vecs[i].sel, vecs[i].din);
         check($sformatf("row%0d ren", i), 32'(ren), 32'(vecs[i].ren));
         if (vecs[i].chk >= 1)
            check($sformatf("row%0d gnt_valid_q", i), 32'(gnt_valid_q), 32'(vecs[i].v));
         if (vecs[i].chk >= 2)
            check($sformatf("row%0d gnt_idx_q", i), 32'(gnt_idx_q), 32'(vecs[i].idx));
      end

      // Same-cycle write and reload of queue a: the reload uses the old
      // weight (1), so the next cycle moves on to b; the new weight 5
      // applies from a's next turn.
      drive(1, 4'b1110, 0, 1, 0, 3'd5);
      check("wr+reload ren", 32'(ren), 32'(4'b0001));
      drive(1, 4'b0000, 0, 0, 0, 3'd0);
      check("old weight used ren", 32'(ren), 32'(4'b0010));
      check("old weight valid", 32'(gnt_valid_q), 32'(1'b1));
      check("old weight idx", 32'(gnt_idx_q), 32'(2'd0));
      drive(1, 4'b0000, 0, 0, 0, 3'd0);
      check("after b ren", 32'(ren), 32'(4'b0100));
      drive(1, 4'b0000, 0, 0, 0, 3'd0);
      check("after c ren", 32'(ren), 32'(4'b1000));
      for (int k = 0; k < 5; k++) begin
         drive(1, 4'b0000, 0, 0, 0, 3'd0);
         check($sformatf("a burst5 grant%0d ren", k), 32'(ren), 32'(4'b0001));
      end
      drive(1, 4'b0000, 0, 0, 0, 3'd0);
      check("after a burst ren", 32'(ren), 32'(4'b0010));

      // Weight 0 disables d: with only d non-empty nothing is granted.
      drive(1, 4'b0000, 1, 1, 3, 3'd0);
      check("stall ren", 32'(ren), 32'(4'b0000));
      drive(1, 4'b0111, 0, 0, 0, 3'd0);
      check("disabled d ren", 32'(ren), 32'(4'b0000));
      check("after stall valid", 32'(gnt_valid_q), 32'(1'b0));
      drive(1, 4'b0111, 0, 0, 0, 3'd0);
      check("disabled d idle ren", 32'(ren), 32'(4'b0000));
      check("disabled d valid", 32'(gnt_valid_q), 32'(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
